// File: rtl/vcb_mod_udl.sv
// Modulo-MOD up/down counter with set, saturating load, cascade enable and optional one-shot stop.
// Priority per edge is r, s, ld, count, hold; TC and CEO are combinational from Q and the live inputs.
module vcb_mod_udl #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MOD     = 16,
    parameter bit              ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ce,
    input  logic             up,
    input  logic             s,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CEO,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 64'd1);

    // Declaration initialisers give the power-up state Q=0, done=0.
    logic [WIDTH-1:0] r_q    = '0;
    logic             r_done = 1'b0;

    logic w_tc;
    logic w_override;
    logic w_step;

    assign w_tc       = (up && (r_q == MAX)) || (!up && (r_q == '0));
    assign w_override = r | s | ld;
    assign w_step     = ce & ~r_done;

    always_ff @(posedge clk) begin
        if (r) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else if (s) begin
            r_q    <= MAX;
            r_done <= 1'b0;
        end else if (ld) begin
            r_q    <= (d > MAX) ? MAX : d;
            r_done <= 1'b0;
        end else if (w_step) begin
            // In one-shot mode the terminal step freezes Q instead of wrapping.
            if (ONESHOT && w_tc) begin
                r_done <= 1'b1;
            end else if (up) begin
                r_q <= (r_q == MAX) ? '0 : r_q + 1'b1;
            end else begin
                r_q <= (r_q == '0) ? MAX : r_q - 1'b1;
            end
        end
    end

    assign Q    = r_q;
    assign TC   = w_tc;
    assign CEO  = ce & w_tc & ~r_done & ~w_override;
    assign done = r_done;

endmodule

// File: tb/tb_vcb_mod_udl.sv
// Directed bench for vcb_mod_udl: several configurations share one set of inputs;
// each vector names the instance it checks and carries hand-computed expected outputs.
module tb_vcb_mod_udl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r  = 1'b1;
    logic       s  = 1'b0;
    logic       ld = 1'b0;
    logic       ce = 1'b0;
    logic       up = 1'b0;
    logic [3:0] d  = 4'd0;

    logic [3:0] qa, qb, qlo, qhi;
    logic [2:0] qc;
    logic       tca, ceoa, donea;
    logic       tcb, ceob, doneb;
    logic       tcc, ceoc, donec;
    logic       tclo, ceolo, donelo;
    logic       tchi, ceohi, donehi;

    // A: decade wrap counter
    vcb_mod_udl #(.WIDTH(4), .MOD(10), .ONESHOT(1'b0)) u_a (
        .clk(clk), .r(r), .ce(ce), .up(up), .s(s), .ld(ld), .d(d),
        .Q(qa), .TC(tca), .CEO(ceoa), .done(donea));

    // B: one-shot modulo 6
    vcb_mod_udl #(.WIDTH(4), .MOD(6), .ONESHOT(1'b1)) u_b (
        .clk(clk), .r(r), .ce(ce), .up(up), .s(s), .ld(ld), .d(d),
        .Q(qb), .TC(tcb), .CEO(ceob), .done(doneb));

    // C: full-range 3-bit counter
    vcb_mod_udl #(.WIDTH(3), .MOD(8), .ONESHOT(1'b0)) u_c (
        .clk(clk), .r(r), .ce(ce), .up(up), .s(s), .ld(ld), .d(d[2:0]),
        .Q(qc), .TC(tcc), .CEO(ceoc), .done(donec));

    // D: two-digit decimal cascade
    vcb_mod_udl #(.WIDTH(4), .MOD(10), .ONESHOT(1'b0)) u_lo (
        .clk(clk), .r(r), .ce(ce), .up(up), .s(s), .ld(ld), .d(d),
        .Q(qlo), .TC(tclo), .CEO(ceolo), .done(donelo));

    vcb_mod_udl #(.WIDTH(4), .MOD(10), .ONESHOT(1'b0)) u_hi (
        .clk(clk), .r(r), .ce(ceolo), .up(up), .s(s), .ld(ld), .d(d),
        .Q(qhi), .TC(tchi), .CEO(ceohi), .done(donehi));

    // Scoreboard entry: {sel[2:0], q[7:0], tc, ceo, done}
    logic [13:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    // Inputs are applied just after a posedge; the expected entry describes
    // what the selected instance shows at the following negedge.
    task automatic vec(input logic [2:0] sel, input bit chk, input string nm,
                       input logic vr, input logic vs, input logic vld,
                       input logic vce, input logic vup, input logic [3:0] vd,
                       input logic [7:0] eq, input logic etc, input logic eceo,
                       input logic edone);
        r  = vr;
        s  = vs;
        ld = vld;
        ce = vce;
        up = vup;
        d  = vd;
        if (chk) begin
            exp_q.push_back({sel, eq, etc, eceo, edone});
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [13:0] e;
        logic [13:0] act;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e[13:11])
                3'd0:    act = {3'd0, 4'd0, qa, tca, ceoa, donea};
                3'd1:    act = {3'd1, 4'd0, qb, tcb, ceob, doneb};
                3'd2:    act = {3'd2, 5'd0, qc, tcc, ceoc, donec};
                default: act = {3'd3, qhi, qlo, tchi, ceohi, donehi};
            endcase
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got q=%0h tc=%0b ceo=%0b done=%0b, expected q=%0h tc=%0b ceo=%0b done=%0b",
                         nm, act[10:3], act[2], act[1], act[0], e[10:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        logic [7:0] q;
        int         n;
        @(posedge clk);
        #1;

        // Reset state, then up count with wrap at 9
        vec(0, 1, "a_reset", 1,0,0,1,1, 0, 8'd0, 0,0,0);
        for (int i = 0; i < 13; i++)
            vec(0, 1, "a_up", 0,0,0,1,1, 0, 8'(i % 10), (i % 10) == 9, (i % 10) == 9, 0);

        // Down count from reset, 0 wraps to 9
        vec(0, 1, "a_reset_dn", 1,0,0,1,0, 0, 8'd3, 0,0,0);
        for (int i = 0; i < 12; i++) begin
            q = 8'((10 - (i % 10)) % 10);
            vec(0, 1, "a_down", 0,0,0,1,0, 0, q, q == 0, q == 0, 0);
        end

        // Priority and saturating load
        vec(0, 1, "a_ld_sat",   0,0,1,0,0, 4'd13, 8'd8, 0,0,0);
        vec(0, 1, "a_s_over_ld",0,1,1,1,1, 4'd3,  8'd9, 1,0,0);
        vec(0, 1, "a_r_over_ld",1,0,1,1,1, 4'd3,  8'd9, 1,0,0);
        vec(0, 1, "a_hold_dn",  0,0,0,0,0, 4'd0,  8'd0, 1,0,0);
        vec(0, 1, "a_ld_9",     0,0,1,0,1, 4'd9,  8'd0, 0,0,0);
        vec(0, 1, "a_ld_5",     0,0,1,1,1, 4'd5,  8'd9, 1,0,0);
        vec(0, 1, "a_hold",     0,0,0,0,1, 4'd0,  8'd5, 0,0,0);
        vec(0, 1, "a_ld_10",    0,0,1,0,0, 4'd10, 8'd5, 0,0,0);
        vec(0, 1, "a_ld_10_q",  0,0,0,0,1, 4'd0,  8'd9, 1,0,0);

        // One-shot modulo 6
        vec(1, 0, "", 1,0,0,0,1, 0, 8'd0, 0,0,0);
        for (int i = 0; i < 8; i++) begin
            q = (i < 5) ? 8'(i) : 8'd5;
            vec(1, 1, "b_run", 0,0,0,1,1, 0, q, q == 5, i == 5, i >= 6);
        end
        vec(1, 1, "b_ce0",     0,0,0,0,1, 4'd0,  8'd5, 1,0,1);
        vec(1, 1, "b_ce1",     0,0,0,1,1, 4'd0,  8'd5, 1,0,1);
        vec(1, 1, "b_dn_done", 0,0,0,1,0, 4'd0,  8'd5, 0,0,1);
        vec(1, 1, "b_ld2",     0,0,1,1,1, 4'd2,  8'd5, 1,0,1);
        vec(1, 1, "b_after_ld",0,0,0,0,1, 4'd0,  8'd2, 0,0,0);
        vec(1, 1, "b_ld_sat",  0,0,1,0,1, 4'd13, 8'd2, 0,0,0);
        vec(1, 1, "b_tc_step", 0,0,0,1,1, 4'd0,  8'd5, 1,1,0);
        vec(1, 1, "b_r_done",  1,0,0,1,1, 4'd0,  8'd5, 1,0,1);
        vec(1, 1, "b_after_r", 0,0,0,0,1, 4'd0,  8'd0, 0,0,0);

        // 3-bit full range with direction change at 7
        vec(2, 0, "", 1,0,0,0,1, 0, 8'd0, 0,0,0);
        vec(2, 1, "c_set",     0,1,0,1,1, 0, 8'd0, 0,0,0);
        vec(2, 1, "c_wrap_up", 0,0,0,1,1, 0, 8'd7, 1,1,0);
        vec(2, 1, "c_wrap_dn", 0,0,0,1,0, 0, 8'd0, 1,1,0);
        vec(2, 1, "c_up_ce0",  0,0,0,0,1, 0, 8'd7, 1,0,0);
        vec(2, 1, "c_toggle",  0,0,0,1,0, 0, 8'd7, 0,0,0);
        vec(2, 1, "c_dn6",     0,0,0,1,0, 0, 8'd6, 0,0,0);
        vec(2, 1, "c_dn5",     0,0,0,1,0, 0, 8'd5, 0,0,0);
        vec(2, 1, "c_freeze",  0,0,0,0,0, 0, 8'd4, 0,0,0);
        vec(2, 1, "c_frozen",  0,0,0,0,0, 0, 8'd4, 0,0,0);

        // Decimal cascade 00..99 and back to 00
        vec(3, 0, "", 1,0,0,0,1, 0, 8'd0, 0,0,0);
        for (int i = 0; i <= 100; i++) begin
            n = i % 100;
            vec(3, 1, "d_cascade", 0,0,0,1,1, 0, {4'(n / 10), 4'(n % 10)},
                (n / 10) == 9, n == 99, 0);
        end

        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vcb_mod_udl.md
VCB_MOD_UDL -- requirements
Module: vcb_mod_udl

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 Parameter MOD, default 16: count modulus, so Q spans 0..MOD-1; legal range 2..2^WIDTH.
REQ-003 Parameter ONESHOT, default 0: 0 = wrap-around mode, 1 = one-shot mode (stops at terminal count).
REQ-004 clk  in  1  clock; all state changes on posedge clk.
REQ-005 r  in  1  reset, synchronous, active-high.
REQ-006 ce  in  1  clock enable; permits one count step per cycle.
REQ-007 up  in  1  direction; 1 = increment, 0 = decrement.
REQ-008 s  in  1  synchronous set of Q to MOD-1.
REQ-009 ld  in  1  synchronous parallel load of d.
REQ-010 d  in  WIDTH  parallel load value.
REQ-011 Q  out  WIDTH  counter value, registered.
REQ-012 TC  out  1  terminal count flag, combinational.
REQ-013 CEO  out  1  cascade enable output, combinational.
REQ-014 done  out  1  one-shot completion flag, registered; constant 0 when ONESHOT=0.

Function
REQ-015 Per-edge priority is fixed, highest first: r, s, ld, count, hold.
REQ-016 r=1: Q<=0, done<=0, regardless of every other input.
REQ-017 s=1 (r=0): Q<=MOD-1, done<=0.
REQ-018 ld=1 (r=0, s=0): Q<=d when d<=MOD-1; Q<=MOD-1 when d>=MOD (saturating load); done<=0.
REQ-019 Count, ce=1 and no higher-priority input and done=0: up=1 gives Q<=Q+1, with MOD-1 wrapping to 0; up=0 gives Q<=Q-1, with 0 wrapping to MOD-1.
REQ-020 Hold, ce=0 or done=1: Q and done keep their values.
REQ-021 TC = (up & Q==MOD-1) | (~up & Q==0); it reacts to up in the same cycle, without waiting for a clock edge.
REQ-022 CEO = ce & TC & ~done & ~r & ~s & ~ld.
REQ-023 ONESHOT=1: a count step taken while TC=1 leaves Q at its present value and sets done<=1, so there is no wrap; CEO is 1 for that one cycle only.
REQ-024 ONESHOT=1, done=1: ce is ignored, TC follows REQ-021, and CEO=0; done is cleared only by r, s or ld.
REQ-025 ONESHOT=0: wrap per REQ-019 and done is held at 0.
REQ-026 A change on up takes effect on the next count edge; no extra latency, no glitch in Q.
REQ-027 Latency: one clock from an input at a posedge to the new Q; TC and CEO are valid in the same cycle as Q and the inputs.
REQ-028 MOD=2^WIDTH: wrap uses natural overflow, with identical results to REQ-019.
REQ-029 Non-power-of-two MOD: Q never takes a value >= MOD by any input sequence after the first reset, set or load.

Reset
REQ-030 Power-up initial values are Q=0 and done=0.
REQ-031 Reset is synchronous only; r asserted between edges has no effect until the next posedge.
REQ-032 r asserted mid-count or with done=1 gives Q=0 and done=0 on the same edge; CEO=0 in every cycle where r=1.

Verification
REQ-033 WIDTH=4, MOD=10, ONESHOT=0, up=1, ce=1 for 12 cycles from reset -> Q=1..9,0,1,2; TC and CEO high exactly when Q=9.
REQ-034 Same config with up=0, ce=1 from reset -> Q=9,8,...; TC and CEO high when Q=0, and the next Q is 9.
REQ-035 WIDTH=4, MOD=10: ld=1, d=13 -> Q=9; then ld=1 together with s=1, d=3 -> Q=9 (s wins); then r=1 together with ld=1 -> Q=0.
REQ-036 ONESHOT=1, MOD=6, up=1, ce=1 from Q=0 -> Q=1..5, then holds at 5; done=1 on the edge after CEO pulses; CEO high for exactly one cycle; ce toggling afterwards leaves Q=5; ld=1, d=2 -> Q=2, done=0.
REQ-037 WIDTH=3, MOD=8: ce=1, up toggled at Q=7 -> TC drops in the same cycle; Q counts 6,5...; ce=0 freezes Q and forces CEO=0.
REQ-038 Cascade two instances, WIDTH=4, MOD=10, low CEO driving high ce, up=1 -> the pair counts 00..99 decimal, and CEO of the high instance pulses at count 99.
